// File: rtl/status_reg.sv
// ----------------------------------------------------------------------------
// status_reg -- 6502-style processor status register (P) with a two-stage
// flag pipeline, explicit flag operations, PLP/RTI load and branch decision.
//
// P layout: {N, V, 1, B, D, I, Z, C}. The stored B bit is always 0 and bit5
// is always 1; B only appears on p_push.
//
// Ports:
//   clk           in   clock, all state updates on the rising edge
//   reset         in   synchronous active-high reset (P = 8'h24)
//   alu_negative  in   ALU N result
//   alu_overflow  in   ALU V result
//   alu_zero      in   ALU Z result
//   alu_c_out     in   ALU C result
//   flag_capture  in   latch ALU flags + mask into the pending stage
//   flag_mask     in   [3:0] {N,V,Z,C} which captured flags commit into P
//   flush         in   discard the pending stage (no commit)
//   flag_op       in   [2:0] 0 none,1 CLC,2 SEC,3 CLI,4 SEI,5 CLD,6 SED,7 CLV
//   load_p        in   load P from data_in (PLP/RTI)
//   data_in       in   [7:0] value for load_p
//   brk_push      in   B value inserted into p_push
//   br_cond       in   [2:0] branch opcode bits [7:5]
//   p_out         out  [7:0] committed P
//   p_push        out  [7:0] P as pushed to stack (B = brk_push)
//   c_fwd         out  carry for the ALU, forwarded from the pending stage
//   bcd           out  decimal-mode flag (P.D)
//   branch_taken  out  branch decision from the forwarded flags
//   pend_valid    out  pending stage holds uncommitted flags
// ----------------------------------------------------------------------------
module status_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_negative,
    input  logic       alu_overflow,
    input  logic       alu_zero,
    input  logic       alu_c_out,
    input  logic       flag_capture,
    input  logic [3:0] flag_mask,
    input  logic       flush,
    input  logic [2:0] flag_op,
    input  logic       load_p,
    input  logic [7:0] data_in,
    input  logic       brk_push,
    input  logic [2:0] br_cond,
    output logic [7:0] p_out,
    output logic [7:0] p_push,
    output logic       c_fwd,
    output logic       bcd,
    output logic       branch_taken,
    output logic       pend_valid
);

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_CLC  = 3'd1;
    localparam logic [2:0] OP_SEC  = 3'd2;
    localparam logic [2:0] OP_CLI  = 3'd3;
    localparam logic [2:0] OP_SEI  = 3'd4;
    localparam logic [2:0] OP_CLD  = 3'd5;
    localparam logic [2:0] OP_SED  = 3'd6;
    localparam logic [2:0] OP_CLV  = 3'd7;

    localparam logic [7:0] P_RESET = 8'h24;

    // Bit positions inside P.
    localparam int unsigned BIT_C = 0;
    localparam int unsigned BIT_Z = 1;
    localparam int unsigned BIT_I = 2;
    localparam int unsigned BIT_D = 3;
    localparam int unsigned BIT_V = 6;
    localparam int unsigned BIT_N = 7;

    logic [7:0] p_reg;
    logic [7:0] next_p;
    logic [7:0] load_val;

    // Pending stage, flags and mask both in {N,V,Z,C} order.
    logic [3:0] pend_flags;
    logic [3:0] pend_mask;

    logic       commit_en;
    logic       fwd_n;
    logic       fwd_v;
    logic       fwd_z;
    logic       fwd_c;

    // A flush on the same edge as a pending commit suppresses the commit.
    assign commit_en = pend_valid && !flush;

    // PLP/RTI value: bit5 forced high, B forced low.
    assign load_val = (data_in | 8'h20) & 8'hEF;

    // Commit masked pending flags first, then let flag_op override the
    // bit it targets so an explicit flag instruction wins a same-edge clash.
    always_comb begin
        next_p = p_reg;
        if (commit_en) begin
            if (pend_mask[3]) next_p[BIT_N] = pend_flags[3];
            if (pend_mask[2]) next_p[BIT_V] = pend_flags[2];
            if (pend_mask[1]) next_p[BIT_Z] = pend_flags[1];
            if (pend_mask[0]) next_p[BIT_C] = pend_flags[0];
        end
        case (flag_op)
            OP_CLC:  next_p[BIT_C] = 1'b0;
            OP_SEC:  next_p[BIT_C] = 1'b1;
            OP_CLI:  next_p[BIT_I] = 1'b0;
            OP_SEI:  next_p[BIT_I] = 1'b1;
            OP_CLD:  next_p[BIT_D] = 1'b0;
            OP_SED:  next_p[BIT_D] = 1'b1;
            OP_CLV:  next_p[BIT_V] = 1'b0;
            OP_NONE: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_reg <= P_RESET;
        end else if (load_p) begin
            p_reg <= load_val;
        end else begin
            p_reg <= next_p;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || load_p || flush) begin
            pend_valid <= 1'b0;
        end else begin
            pend_valid <= flag_capture;
        end
        if (flag_capture) begin
            pend_flags <= {alu_negative, alu_overflow, alu_zero, alu_c_out};
            pend_mask  <= flag_mask;
        end
    end

    // Forwarding: a valid pending flag whose mask bit is set shadows P.
    assign fwd_n = (pend_valid && pend_mask[3]) ? pend_flags[3] : p_reg[BIT_N];
    assign fwd_v = (pend_valid && pend_mask[2]) ? pend_flags[2] : p_reg[BIT_V];
    assign fwd_z = (pend_valid && pend_mask[1]) ? pend_flags[1] : p_reg[BIT_Z];
    assign fwd_c = (pend_valid && pend_mask[0]) ? pend_flags[0] : p_reg[BIT_C];

    always_comb begin
        case (br_cond[2:1])
            2'b00:   branch_taken = (fwd_n == br_cond[0]);
            2'b01:   branch_taken = (fwd_v == br_cond[0]);
            2'b10:   branch_taken = (fwd_c == br_cond[0]);
            default: branch_taken = (fwd_z == br_cond[0]);
        endcase
    end

    assign c_fwd  = fwd_c;
    assign bcd    = p_reg[BIT_D];
    assign p_out  = p_reg;
    assign p_push = {p_reg[7:6], 1'b1, brk_push, p_reg[3:0]};

endmodule

// File: tb/tb_status_reg.sv
// ----------------------------------------------------------------------------
// tb_status_reg -- self-checking bench for status_reg. Directed scenarios
// followed by randomized stimulus compared against a byte-level reference
// model of P and the pending stage.
// ----------------------------------------------------------------------------
module tb_status_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_negative;
    logic       alu_overflow;
    logic       alu_zero;
    logic       alu_c_out;
    logic       flag_capture;
    logic [3:0] flag_mask;
    logic       flush;
    logic [2:0] flag_op;
    logic       load_p;
    logic [7:0] data_in;
    logic       brk_push;
    logic [2:0] br_cond;
    logic [7:0] p_out;
    logic [7:0] p_push;
    logic       c_fwd;
    logic       bcd;
    logic       branch_taken;
    logic       pend_valid;

    always #5 clk = ~clk;

    status_reg dut (
        .clk          (clk),
        .reset        (reset),
        .alu_negative (alu_negative),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .alu_c_out    (alu_c_out),
        .flag_capture (flag_capture),
        .flag_mask    (flag_mask),
        .flush        (flush),
        .flag_op      (flag_op),
        .load_p       (load_p),
        .data_in      (data_in),
        .brk_push     (brk_push),
        .br_cond      (br_cond),
        .p_out        (p_out),
        .p_push       (p_push),
        .c_fwd        (c_fwd),
        .bcd          (bcd),
        .branch_taken (branch_taken),
        .pend_valid   (pend_valid)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: P as a byte, pending flags/mask in {N,V,Z,C} order.
    logic [7:0] m_p  = 8'h00;
    logic       m_pv = 1'b0;
    logic [3:0] m_pf = 4'h0;
    logic [3:0] m_pm = 4'h0;

    // flag_op table: target bit in P and the value written.
    int unsigned op_bit [8] = '{0, 0, 0, 2, 2, 3, 3, 6};
    logic        op_val [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    // Branch flag select by br_cond[2:1]: N, V, C, Z.
    int unsigned br_bit [4] = '{7, 6, 0, 1};

    task automatic check_val(input string tag, input logic [7:0] got,
                             input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Place {N,V,Z,C} into their P bit positions.
    function automatic logic [7:0] spread(input logic [3:0] nvzc);
        logic [7:0] r;
        r = 8'h00;
        r[7] = nvzc[3];
        r[6] = nvzc[2];
        r[1] = nvzc[1];
        r[0] = nvzc[0];
        return r;
    endfunction

    function automatic logic [7:0] merged_flags();
        logic [7:0] m;
        m = spread(m_pm);
        return (m_p & ~m) | (spread(m_pf) & m);
    endfunction

    task automatic compare_all(input string tag);
        logic [7:0] f;
        logic [7:0] push_exp;
        f = m_pv ? merged_flags() : m_p;
        push_exp = (m_p & 8'hEF) | 8'h20 | (brk_push ? 8'h10 : 8'h00);
        check_val({tag, ".p_out"},  p_out,  m_p);
        check_val({tag, ".p_push"}, p_push, push_exp);
        check_val({tag, ".c_fwd"},  {7'd0, c_fwd},  {7'd0, f[0]});
        check_val({tag, ".bcd"},    {7'd0, bcd},    {7'd0, m_p[3]});
        check_val({tag, ".branch"}, {7'd0, branch_taken},
                  {7'd0, f[br_bit[br_cond[2:1]]] == br_cond[0]});
        check_val({tag, ".pend"},   {7'd0, pend_valid}, {7'd0, m_pv});
    endtask

    // Advance one clock edge, updating the model from the held inputs.
    task automatic tick(input string tag);
        logic [7:0] np;
        logic       npv;
        logic [3:0] npf;
        logic [3:0] npm;
        np  = m_p;
        npv = 1'b0;
        npf = m_pf;
        npm = m_pm;
        if (flag_capture) begin
            npf = {alu_negative, alu_overflow, alu_zero, alu_c_out};
            npm = flag_mask;
        end
        if (reset) begin
            np = 8'h24;
        end else if (load_p) begin
            np = (data_in | 8'h20) & 8'hEF;
        end else begin
            if (m_pv && !flush) np = merged_flags();
            if (flag_op != 3'd0) np[op_bit[flag_op]] = op_val[flag_op];
            npv = flag_capture && !flush;
        end
        @(posedge clk);
        #1;
        m_p  = np;
        m_pv = npv;
        m_pf = npf;
        m_pm = npm;
        compare_all(tag);
    endtask

    task automatic set_idle();
        reset        = 1'b0;
        alu_negative = 1'b0;
        alu_overflow = 1'b0;
        alu_zero     = 1'b0;
        alu_c_out    = 1'b0;
        flag_capture = 1'b0;
        flag_mask    = 4'h0;
        flush        = 1'b0;
        flag_op      = 3'd0;
        load_p       = 1'b0;
        data_in      = 8'h00;
        brk_push     = 1'b0;
        br_cond      = 3'd0;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        tick("rst");
        reset = 1'b0;
    endtask

    initial begin
        // Reset state and the cycle after.
        do_reset();
        check_val("reset_p_out", p_out, 8'h24);
        check_val("reset_pend", {7'd0, pend_valid}, 8'h00);
        tick("idle");
        check_val("post_reset_c_fwd", {7'd0, c_fwd}, 8'h00);
        check_val("post_reset_bcd", {7'd0, bcd}, 8'h00);
        check_val("post_reset_p_push", p_push, 8'h24);

        // Capture N=1,V=0,Z=0,C=1 with mask NZC, then commit.
        alu_negative = 1'b1;
        alu_c_out    = 1'b1;
        flag_mask    = 4'b1011;
        flag_capture = 1'b1;
        tick("cap1");
        check_val("cap1_pend", {7'd0, pend_valid}, 8'h01);
        check_val("cap1_c_fwd", {7'd0, c_fwd}, 8'h01);
        check_val("cap1_p_out_uncommitted", p_out, 8'h24);
        set_idle();
        tick("commit1");
        check_val("commit1_p_out", p_out, 8'hA5);

        // Capture C then flush before commit.
        do_reset();
        alu_c_out    = 1'b1;
        flag_mask    = 4'b0001;
        flag_capture = 1'b1;
        tick("capc");
        check_val("capc_c_fwd", {7'd0, c_fwd}, 8'h01);
        set_idle();
        flush = 1'b1;
        #1;
        check_val("flush_c_fwd_pending", {7'd0, c_fwd}, 8'h01);
        tick("flush");
        check_val("flush_p_c", {7'd0, p_out[0]}, 8'h00);
        check_val("flush_c_fwd", {7'd0, c_fwd}, 8'h00);
        check_val("flush_pend", {7'd0, pend_valid}, 8'h00);

        // Load P while a commit is pending.
        set_idle();
        alu_c_out    = 1'b1;
        alu_zero     = 1'b1;
        flag_mask    = 4'b1111;
        flag_capture = 1'b1;
        tick("capload");
        set_idle();
        load_p  = 1'b1;
        data_in = 8'hFF;
        tick("load");
        check_val("load_p_out", p_out, 8'hEF);
        check_val("load_pend", {7'd0, pend_valid}, 8'h00);

        // CLC on the commit edge of a pending C=1.
        do_reset();
        alu_c_out    = 1'b1;
        flag_mask    = 4'b0001;
        flag_capture = 1'b1;
        tick("capclc");
        set_idle();
        flag_op = 3'd1;
        tick("clc");
        check_val("clc_p_c", {7'd0, p_out[0]}, 8'h00);

        // Branch from forwarded Z before commit.
        do_reset();
        alu_zero     = 1'b1;
        flag_mask    = 4'b0010;
        flag_capture = 1'b1;
        tick("capz");
        set_idle();
        br_cond = 3'b111;
        #1;
        check_val("beq_taken", {7'd0, branch_taken}, 8'h01);
        check_val("beq_p_out", p_out, 8'h24);
        br_cond = 3'b110;
        #1;
        check_val("bne_not_taken", {7'd0, branch_taken}, 8'h00);
        compare_all("brz");
        tick("commitz");

        // B only on p_push; reset mid-pending.
        do_reset();
        tick("idle2");
        brk_push = 1'b1;
        #1;
        check_val("brk_p_push", p_push, 8'h34);
        check_val("brk_p_out", p_out, 8'h24);
        set_idle();
        alu_negative = 1'b1;
        flag_mask    = 4'b1111;
        flag_capture = 1'b1;
        tick("capn");
        check_val("capn_pend", {7'd0, pend_valid}, 8'h01);
        reset = 1'b1;
        tick("rst_pend");
        check_val("rst_pend_p_out", p_out, 8'h24);
        check_val("rst_pend_pend", {7'd0, pend_valid}, 8'h00);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(63) == 0);
            alu_negative = $urandom_range(1);
            alu_overflow = $urandom_range(1);
            alu_zero     = $urandom_range(1);
            alu_c_out    = $urandom_range(1);
            flag_capture = ($urandom_range(1) == 1);
            flag_mask    = 4'($urandom_range(15));
            flush        = ($urandom_range(7) == 0);
            flag_op      = ($urandom_range(1) == 1) ? 3'($urandom_range(7)) : 3'd0;
            load_p       = ($urandom_range(15) == 0);
            data_in      = 8'($urandom_range(255));
            brk_push     = $urandom_range(1);
            br_cond      = 3'($urandom_range(7));
            #1;
            compare_all("rnd_pre");
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
